// File: rtl/channel_array_pkg.sv
// Shared constants for the multi-channel sample aggregator:
// register map, bus modes and output word field layout.
package channel_array_pkg;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_CHMASK = 6'h01;
  localparam logic [5:0] ADDR_OVF    = 6'h02;
  localparam logic [5:0] ADDR_DROPS  = 6'h03;
  localparam logic [5:0] ADDR_INFO   = 6'h04;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_WRITE = 2'b01,
    MODE_READ  = 2'b10,
    MODE_IDLE2 = 2'b11
  } busMode_t;

  localparam int SEQ_W = 5;
  localparam int CH_W  = 3;

  // Offsets above the sample field in the output word
  localparam int SEQ_OFS = 0;
  localparam int CH_OFS  = SEQ_W;

  function automatic logic [7:0] satAdd(
    input logic [7:0] a,
    input logic [3:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + 9'(b);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/channel_array_top_sample_fifo.sv
// Per-channel synchronous sample FIFO with flush.
// Pointers carry one extra wrap bit to tell full from empty.
module sample_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             doPush;
  logic             doPop;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) &&
                 (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign popData = mem[rdPtr[AW-1:0]];

  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/channel_array_top.sv
// Multi-channel capture with round-robin readout into one tagged word.
// Define CHANNEL_ARRAY_DROP_COUNT_EN to build the DROPS counter.
module channel_array_top
  import channel_array_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_W     = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CHANNELS-1:0]          i_SampleValid,
  input  logic [NUM_CHANNELS*SAMPLE_W-1:0] i_SampleData,
  input  logic [1:0]                       i_Mode,
  input  logic [5:0]                       i_Addr,
  input  logic [7:0]                       i_DataIn,
  output logic [7:0]                       o_DataOut,
  input  logic                             i_MasterEnable,
  input  logic                             i_ReadSample,
  output logic                             o_ReadSampleEmpty,
  output logic [8+SAMPLE_W-1:0]            o_ReadSampleData
);

  localparam int ENTRY_W = SEQ_W + SAMPLE_W;
  localparam int OUT_W   = CH_W + ENTRY_W;
  localparam int N       = NUM_CHANNELS;

  busMode_t          mode;
  logic              busWrite;
  logic              flush;
  logic              ctrlEnable;
  logic [N-1:0]      chMask;
  logic [N-1:0]      ovf;
  logic [N-1:0]      ovfClr;
  logic [N-1:0]      qual;
  logic [N-1:0]      fifoPush;
  logic [N-1:0]      fifoPop;
  logic [N-1:0]      fifoFull;
  logic [N-1:0]      fifoEmpty;
  logic [N-1:0]      dropMask;
  logic [ENTRY_W-1:0] popData [N];
  logic [ENTRY_W-1:0] grantEntry;
  logic [SEQ_W-1:0]  seqCnt [N];
  logic [CH_W-1:0]   lastGrant;
  logic [CH_W-1:0]   grant;
  logic              grantValid;
  logic              loadNow;
  logic              holdValid;
  logic [OUT_W-1:0]  holdData;
  logic [7:0]        dataOut;
  logic [7:0]        rdMux;
  logic              unusedData;

  assign mode     = busMode_t'(i_Mode);
  assign busWrite = (mode == MODE_WRITE);
  assign flush    = busWrite && (i_Addr == ADDR_CTRL) && i_DataIn[1];
  assign ovfClr   = (busWrite && i_Addr == ADDR_OVF) ? i_DataIn[N-1:0] : '0;
  assign loadNow  = (!holdValid || i_ReadSample) && grantValid && !flush;
  assign unusedData = ^i_DataIn;

  // Search order starts just after the last granted channel
  always_comb begin
    grant      = lastGrant;
    grantValid = 1'b0;
    grantEntry = '0;
    for (int i = 1; i <= N; i++) begin
      for (int c = 0; c < N; c++) begin
        if (!grantValid && !fifoEmpty[c] &&
            int'(lastGrant) == (c - i + N) % N) begin
          grant      = CH_W'(c);
          grantValid = 1'b1;
        end
      end
    end
    for (int c = 0; c < N; c++) begin
      if (grant == CH_W'(c)) grantEntry = popData[c];
    end
  end

  always_comb begin
    qual     = '0;
    fifoPop  = '0;
    fifoPush = '0;
    dropMask = '0;
    for (int c = 0; c < N; c++) begin
      qual[c] = i_SampleValid[c] && i_MasterEnable &&
                ctrlEnable && chMask[c];
      fifoPop[c] = loadNow && (grant == CH_W'(c));
      fifoPush[c] = qual[c] && !flush &&
                    (!fifoFull[c] || fifoPop[c]);
      dropMask[c] = qual[c] && !flush &&
                    fifoFull[c] && !fifoPop[c];
    end
  end

  for (genvar c = 0; c < N; c++) begin : gChan
    sample_fifo #(
      .WIDTH(ENTRY_W),
      .DEPTH(FIFO_DEPTH)
    ) uFifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .push    (fifoPush[c]),
      .pushData({seqCnt[c], i_SampleData[c*SAMPLE_W +: SAMPLE_W]}),
      .pop     (fifoPop[c]),
      .popData (popData[c]),
      .full    (fifoFull[c]),
      .empty   (fifoEmpty[c])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < N; c++) seqCnt[c] <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (flush)        seqCnt[c] <= '0;
        else if (qual[c]) seqCnt[c] <= seqCnt[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      holdValid <= 1'b0;
      holdData  <= '0;
      lastGrant <= CH_W'(N - 1);
    end else if (flush) begin
      holdValid <= 1'b0;
      holdData  <= '0;
      lastGrant <= CH_W'(N - 1);
    end else if (loadNow) begin
      holdValid <= 1'b1;
      holdData  <= {grant, grantEntry};
      lastGrant <= grant;
    end else if (i_ReadSample) begin
      holdValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlEnable <= 1'b0;
      chMask     <= '1;
      ovf        <= '0;
    end else begin
      if (busWrite && i_Addr == ADDR_CTRL)
        ctrlEnable <= i_DataIn[0];
      if (busWrite && i_Addr == ADDR_CHMASK)
        chMask <= i_DataIn[N-1:0];
      ovf <= (ovf | dropMask) & ~ovfClr;
    end
  end

`ifdef CHANNEL_ARRAY_DROP_COUNT_EN
  logic [7:0] drops;
  logic [3:0] dropCnt;

  always_comb begin
    dropCnt = '0;
    for (int c = 0; c < N; c++) dropCnt = dropCnt + 4'(dropMask[c]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      drops <= '0;
    else if (busWrite && i_Addr == ADDR_DROPS)
      drops <= '0;
    else
      drops <= satAdd(drops, dropCnt);
  end
`endif

  always_comb begin
    rdMux = '0;
    unique case (i_Addr)
      ADDR_CTRL:   rdMux[0] = ctrlEnable;
      ADDR_CHMASK: rdMux[N-1:0] = chMask;
      ADDR_OVF:    rdMux[N-1:0] = ovf;
`ifdef CHANNEL_ARRAY_DROP_COUNT_EN
      ADDR_DROPS:  rdMux = drops;
`endif
      ADDR_INFO:   rdMux = {4'($clog2(FIFO_DEPTH)), 4'(N)};
      default:     rdMux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 dataOut <= '0;
    else if (mode == MODE_READ) dataOut <= rdMux;
  end

  assign o_DataOut         = dataOut;
  assign o_ReadSampleEmpty = !holdValid;
  assign o_ReadSampleData  = holdData;

endmodule

// File: tb/tb_channel_array_top.sv
// Bench for channel_array_top: register table, then scoreboarded
// capture/readout sequences with bounded waits.
module tb_channel_array_top;
  import channel_array_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  i_SampleValid;
  logic [31:0] i_SampleData;
  logic [1:0]  i_Mode;
  logic [5:0]  i_Addr;
  logic [7:0]  i_DataIn;
  logic [7:0]  o_DataOut;
  logic        i_MasterEnable;
  logic        i_ReadSample;
  logic        o_ReadSampleEmpty;
  logic [15:0] o_ReadSampleData;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] sb[$];

`ifdef CHANNEL_ARRAY_DROP_COUNT_EN
  localparam logic [7:0] EXP_DROPS = 8'd1;
`else
  localparam logic [7:0] EXP_DROPS = 8'd0;
`endif

  typedef struct {
    bit         wr;
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } regVec_t;

  regVec_t regTab[15];

  channel_array_top dut (
    .clk              (clk),
    .reset            (reset),
    .i_SampleValid    (i_SampleValid),
    .i_SampleData     (i_SampleData),
    .i_Mode           (i_Mode),
    .i_Addr           (i_Addr),
    .i_DataIn         (i_DataIn),
    .o_DataOut        (o_DataOut),
    .i_MasterEnable   (i_MasterEnable),
    .i_ReadSample     (i_ReadSample),
    .o_ReadSampleEmpty(o_ReadSampleEmpty),
    .o_ReadSampleData (o_ReadSampleData)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h need %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mkWord(input logic [2:0] ch,
                                         input logic [4:0] seq,
                                         input logic [7:0] d);
    return {ch, seq, d};
  endfunction

  task automatic regWrite(input logic [5:0] a, input logic [7:0] d);
    i_Mode = 2'b01; i_Addr = a; i_DataIn = d;
    step();
    i_Mode = 2'b00; i_DataIn = '0;
  endtask

  task automatic regRead(input logic [5:0] a, output logic [7:0] d);
    i_Mode = 2'b10; i_Addr = a;
    step();
    d = o_DataOut;
    i_Mode = 2'b00;
  endtask

  task automatic regCheck(input string name, input logic [5:0] a,
                          input logic [7:0] exp);
    logic [7:0] v;
    regRead(a, v);
    check(name, v, exp);
  endtask

  task automatic inject(input logic [3:0] m, input logic [31:0] d);
    i_SampleValid = m; i_SampleData = d;
    step();
    i_SampleValid = '0; i_SampleData = '0;
  endtask

  task automatic popCheck(input string name);
    int n = 0;
    while (o_ReadSampleEmpty && n < 20) begin
      step();
      n++;
    end
    if (o_ReadSampleEmpty) begin
      compared++;
      mismatched++;
      $display("FAIL %s: timeout got empty need word %h", name, sb[0]);
      void'(sb.pop_front());
    end else begin
      check(name, o_ReadSampleData, sb.pop_front());
      i_ReadSample = 1'b1;
      step();
      i_ReadSample = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    while (sb.size() > 0) popCheck(name);
    check({name, "Empty"}, o_ReadSampleEmpty, 1);
  endtask

  initial begin
    reset = 1'b0;
    i_SampleValid = '0; i_SampleData = '0;
    i_Mode = '0; i_Addr = '0; i_DataIn = '0;
    i_MasterEnable = 1'b1; i_ReadSample = 1'b0;

    regTab[0]  = '{0, ADDR_CTRL,   8'h00, 8'h00, "ctrlRst"};
    regTab[1]  = '{0, ADDR_CHMASK, 8'h00, 8'h0F, "chmaskRst"};
    regTab[2]  = '{0, ADDR_OVF,    8'h00, 8'h00, "ovfRst"};
    regTab[3]  = '{0, ADDR_DROPS,  8'h00, 8'h00, "dropsRst"};
    regTab[4]  = '{0, ADDR_INFO,   8'h00, 8'h34, "info"};
    regTab[5]  = '{0, 6'h05,       8'h00, 8'h00, "unmapped05"};
    regTab[6]  = '{1, ADDR_INFO,   8'hFF, 8'h00, ""};
    regTab[7]  = '{0, ADDR_INFO,   8'h00, 8'h34, "infoRo"};
    regTab[8]  = '{1, ADDR_CHMASK, 8'hFA, 8'h00, ""};
    regTab[9]  = '{0, ADDR_CHMASK, 8'h00, 8'h0A, "chmaskBits"};
    regTab[10] = '{1, ADDR_CHMASK, 8'hFF, 8'h00, ""};
    regTab[11] = '{1, 6'h3F,       8'h55, 8'h00, ""};
    regTab[12] = '{0, 6'h3F,       8'h00, 8'h00, "unmapped3F"};
    regTab[13] = '{1, ADDR_CTRL,   8'h01, 8'h00, ""};
    regTab[14] = '{0, ADDR_CTRL,   8'h00, 8'h01, "ctrlEn"};

    step();
    check("rstEmpty", o_ReadSampleEmpty, 1);
    check("rstData", o_ReadSampleData, 0);
    check("rstDataOut", o_DataOut, 0);
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      if (regTab[i].wr) regWrite(regTab[i].addr, regTab[i].data);
      else regCheck(regTab[i].name, regTab[i].addr, regTab[i].exp);
    end

    // single sample on ch2
    inject(4'b0100, 32'h005A_0000);
    check("t1EmptyK", o_ReadSampleEmpty, 1);
    step();
    check("t1Empty", o_ReadSampleEmpty, 0);
    check("t1Word", o_ReadSampleData, mkWord(3'd2, 5'd0, 8'h5A));
    i_ReadSample = 1'b1;
    step();
    i_ReadSample = 1'b0;
    check("t1PopEmpty", o_ReadSampleEmpty, 1);

    // all channels at once, round-robin order
    regWrite(ADDR_CTRL, 8'h03);
    regCheck("flushSelfClr", ADDR_CTRL, 8'h01);
    inject(4'hF, 32'h1312_1110);
    for (int c = 0; c < 4; c++)
      sb.push_back(mkWord(3'(c), 5'd0, 8'(8'h10 + c)));
    drain("t2");

    // overflow on ch1, then push into full FIFO with a pop
    regWrite(ADDR_CTRL, 8'h03);
    for (int i = 0; i < 10; i++)
      inject(4'b0010, 32'(8'h20 + i) << 8);
    for (int i = 0; i < 9; i++)
      sb.push_back(mkWord(3'd1, 5'(i), 8'(8'h20 + i)));
    regCheck("t3Ovf", ADDR_OVF, 8'h02);
    regCheck("t3Drops", ADDR_DROPS, EXP_DROPS);
    check("t3Head", o_ReadSampleData, sb.pop_front());
    i_ReadSample = 1'b1;
    i_SampleValid = 4'b0010;
    i_SampleData = 32'h0000_2A00;
    step();
    i_ReadSample = 1'b0;
    i_SampleValid = '0;
    i_SampleData = '0;
    sb.push_back(mkWord(3'd1, 5'd10, 8'h2A));
    regCheck("t3NoDrop", ADDR_DROPS, EXP_DROPS);
    drain("t3");
    regWrite(ADDR_OVF, 8'h02);
    regCheck("t3OvfClr", ADDR_OVF, 8'h00);
    regWrite(ADDR_DROPS, 8'h00);
    regCheck("t3DropsClr", ADDR_DROPS, 8'h00);

    // channel mask and master gate
    regWrite(ADDR_CTRL, 8'h03);
    regWrite(ADDR_CHMASK, 8'h0E);
    inject(4'hF, 32'h4342_4140);
    for (int c = 1; c < 4; c++)
      sb.push_back(mkWord(3'(c), 5'd0, 8'(8'h40 + c)));
    drain("t4");
    i_MasterEnable = 1'b0;
    inject(4'b0010, 32'h0000_5500);
    step();
    step();
    check("t4MasterGate", o_ReadSampleEmpty, 1);
    i_MasterEnable = 1'b1;
    regWrite(ADDR_CHMASK, 8'hFF);
    inject(4'b0011, 32'h0000_5150);
    sb.push_back(mkWord(3'd0, 5'd0, 8'h50));
    sb.push_back(mkWord(3'd1, 5'd1, 8'h51));
    drain("t4Seq");

    // flush with buffered ch3 data and a sample in the flush cycle
    regWrite(ADDR_CTRL, 8'h03);
    for (int i = 0; i < 5; i++)
      inject(4'b1000, 32'(8'h60 + i) << 24);
    step();
    i_SampleValid = 4'b1000;
    i_SampleData = 32'h9900_0000;
    regWrite(ADDR_CTRL, 8'h03);
    i_SampleValid = '0;
    i_SampleData = '0;
    check("t5FlushEmpty", o_ReadSampleEmpty, 1);
    regCheck("t5OvfZero", ADDR_OVF, 8'h00);
    regCheck("t5DropsZero", ADDR_DROPS, 8'h00);
    inject(4'b1000, 32'h7700_0000);
    sb.push_back(mkWord(3'd3, 5'd0, 8'h77));
    drain("t5");

    // reset in the middle of readout
    for (int i = 0; i < 3; i++)
      inject(4'b0001, 32'(8'h80 + i));
    regCheck("t6Info", ADDR_INFO, 8'h34);
    i_ReadSample = 1'b1;
    step();
    i_ReadSample = 1'b0;
    check("t6PreRst", o_ReadSampleEmpty, 0);
    #2 reset = 1'b0;
    #1;
    check("t6RstEmpty", o_ReadSampleEmpty, 1);
    check("t6RstData", o_ReadSampleData, 0);
    check("t6RstDataOut", o_DataOut, 0);
    step();
    reset = 1'b1;
    regCheck("t6Ctrl", ADDR_CTRL, 8'h00);
    regCheck("t6Chmask", ADDR_CHMASK, 8'h0F);
    inject(4'b0001, 32'h0000_00AA);
    step();
    step();
    check("t6NoCapture", o_ReadSampleEmpty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
